// File: rtl/rename_map_table_multi.sv
// Speculative/committed arch->phys rename maps; reads are combinational, writes land next edge.
// Rewind walks stable->newest in chunks with busy high. Define RENAME_STABLE_BYPASS_EN to forward commits to readStable.
module rename_map_table_multi #(
    parameter int ARCH_REGS         = 32,
    parameter int PHYS_W            = 6,
    parameter int WIDTH             = 4,
    parameter int READ_PORTS        = 3,
    parameter int RESTORE_PER_CYCLE = 8,
    localparam int ARCH_W           = $clog2(ARCH_REGS)
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         en,
    input  logic                         rewind,
    input  logic                         reserve,
    input  logic [WIDTH-1:0]             allowReserve,
    input  logic [WIDTH*ARCH_W-1:0]      selectReserve,
    input  logic [WIDTH*PHYS_W-1:0]      writeReserve,
    input  logic                         commit,
    input  logic [WIDTH-1:0]             allowCommit,
    input  logic [WIDTH*ARCH_W-1:0]      selectCommit,
    input  logic [WIDTH*PHYS_W-1:0]      writeCommit,
    input  logic [READ_PORTS*ARCH_W-1:0] select,
    output logic [READ_PORTS*PHYS_W-1:0] read,
    input  logic [ARCH_W-1:0]            selectStable,
    output logic [PHYS_W-1:0]            readStable,
    output logic                         busy
);

    localparam int RESTORE_CYCLES = (ARCH_REGS + RESTORE_PER_CYCLE - 1) / RESTORE_PER_CYCLE;
    localparam int CNT_W = (RESTORE_CYCLES > 1) ? $clog2(RESTORE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(RESTORE_CYCLES - 1);

    typedef enum logic {IDLE, RESTORE} state_t;

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  chunk, chunk_nxt;
    logic [PHYS_W-1:0] newest     [ARCH_REGS];
    logic [PHYS_W-1:0] stable     [ARCH_REGS];
    logic [PHYS_W-1:0] newest_nxt [ARCH_REGS];
    logic [PHYS_W-1:0] stable_nxt [ARCH_REGS];
    logic              copy_chunk;
    logic              commit_to_newest;
    int                chunk_base;

    always_comb begin
        state_nxt        = state;
        chunk_nxt        = chunk;
        newest_nxt       = newest;
        stable_nxt       = stable;
        copy_chunk       = 1'b0;
        commit_to_newest = 1'b0;
        chunk_base       = int'(chunk) * RESTORE_PER_CYCLE;

        if (en) begin
            case (state)
                IDLE: begin
                    if (rewind) begin
                        state_nxt        = RESTORE;
                        chunk_nxt        = '0;
                        commit_to_newest = 1'b1;
                    end
                end
                RESTORE: begin
                    copy_chunk       = 1'b1;
                    commit_to_newest = 1'b1;
                    if (rewind) begin
                        chunk_nxt = '0;
                    end else if (chunk == LAST_CHUNK) begin
                        state_nxt = IDLE;
                        chunk_nxt = '0;
                    end else begin
                        chunk_nxt = chunk + 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end

        // Entry 0 is hardwired, so the walk starts at 1.
        if (copy_chunk) begin
            for (int j = 1; j < ARCH_REGS; j++) begin
                if (j >= chunk_base && j < chunk_base + RESTORE_PER_CYCLE)
                    newest_nxt[j] = stable[j];
            end
        end

        if (en && state == IDLE && !rewind && reserve) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (allowReserve[k] && selectReserve[k*ARCH_W +: ARCH_W] != '0)
                    newest_nxt[selectReserve[k*ARCH_W +: ARCH_W]] = writeReserve[k*PHYS_W +: PHYS_W];
            end
        end

        // Applied after the chunk copy so a same-cycle commit overrides the restored value.
        if (en && commit) begin
            for (int k = 0; k < WIDTH; k++) begin
                if (allowCommit[k] && selectCommit[k*ARCH_W +: ARCH_W] != '0) begin
                    stable_nxt[selectCommit[k*ARCH_W +: ARCH_W]] = writeCommit[k*PHYS_W +: PHYS_W];
                    if (commit_to_newest)
                        newest_nxt[selectCommit[k*ARCH_W +: ARCH_W]] = writeCommit[k*PHYS_W +: PHYS_W];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            chunk <= '0;
            for (int i = 0; i < ARCH_REGS; i++) begin
                newest[i] <= PHYS_W'(i);
                stable[i] <= PHYS_W'(i);
            end
        end else begin
            state  <= state_nxt;
            chunk  <= chunk_nxt;
            newest <= newest_nxt;
            stable <= stable_nxt;
        end
    end

    assign busy = (state == RESTORE);

    always_comb begin
        read = '0;
        for (int p = 0; p < READ_PORTS; p++)
            read[p*PHYS_W +: PHYS_W] = newest[select[p*ARCH_W +: ARCH_W]];
    end

`ifdef RENAME_STABLE_BYPASS_EN
    always_comb begin
        readStable = stable[selectStable];
        for (int k = 0; k < WIDTH; k++) begin
            if (en && commit && allowCommit[k] && selectCommit[k*ARCH_W +: ARCH_W] != '0 &&
                selectCommit[k*ARCH_W +: ARCH_W] == selectStable)
                readStable = writeCommit[k*PHYS_W +: PHYS_W];
        end
    end
`else
    assign readStable = stable[selectStable];
`endif

endmodule

// File: tb/tb_rename_map_table_multi.sv
// Directed bench for rename_map_table_multi: per-cycle vector table plus hand-written restore sequences.
module tb_rename_map_table_multi;
    localparam int AW = 5, PW = 6, W = 4, RP = 3;

`ifdef RENAME_STABLE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, en, rewind, reserve, commit, busy;
    logic [W-1:0]     allowReserve, allowCommit;
    logic [W*AW-1:0]  selectReserve, selectCommit;
    logic [W*PW-1:0]  writeReserve, writeCommit;
    logic [RP*AW-1:0] select;
    logic [RP*PW-1:0] read;
    logic [AW-1:0]    selectStable;
    logic [PW-1:0]    readStable;

    rename_map_table_multi dut (
        .clk(clk), .reset(reset), .en(en), .rewind(rewind),
        .reserve(reserve), .allowReserve(allowReserve), .selectReserve(selectReserve), .writeReserve(writeReserve),
        .commit(commit), .allowCommit(allowCommit), .selectCommit(selectCommit), .writeCommit(writeCommit),
        .select(select), .read(read), .selectStable(selectStable), .readStable(readStable), .busy(busy)
    );

    typedef struct {
        logic          en, rw, rsv;
        logic [3:0]    ar;
        logic [19:0]   sr;
        logic [23:0]   wr;
        logic          cm;
        logic [3:0]    ac;
        logic [19:0]   sc;
        logic [23:0]   wc;
        logic [14:0]   sel;
        logic [4:0]    ss;
        logic [17:0]   exp_read;
        logic [5:0]    exp_rs;
        logic          exp_busy;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    function automatic vec_t mk(input logic e, input logic rw, input logic rsv, input logic [3:0] ar,
                                input logic [19:0] sr, input logic [23:0] wr, input logic cm,
                                input logic [3:0] ac, input logic [19:0] sc, input logic [23:0] wc,
                                input logic [4:0] s0, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] ss, input logic [5:0] e0, input logic [5:0] e1,
                                input logic [5:0] e2, input logic [5:0] ers, input logic eb);
        vec_t v;
        v.en = e; v.rw = rw; v.rsv = rsv; v.ar = ar; v.sr = sr; v.wr = wr;
        v.cm = cm; v.ac = ac; v.sc = sc; v.wc = wc;
        v.sel = {s2, s1, s0}; v.ss = ss;
        v.exp_read = {e2, e1, e0}; v.exp_rs = ers; v.exp_busy = eb;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic idle_inputs();
        en = 1'b1; rewind = 1'b0; reserve = 1'b0; commit = 1'b0;
        allowReserve = '0; selectReserve = '0; writeReserve = '0;
        allowCommit = '0; selectCommit = '0; writeCommit = '0;
        select = '0; selectStable = '0;
    endtask

    task automatic commit1(input int ch, input logic [4:0] sel, input logic [5:0] tag);
        commit = 1'b1;
        allowCommit[ch] = 1'b1;
        selectCommit[ch*AW +: AW] = sel;
        writeCommit[ch*PW +: PW] = tag;
    endtask

    vec_t tv [13];

    initial begin
        reset = 1'b0;
        idle_inputs();

        //          en rw rsv ar       sr                          wr                            cm ac       sc                          wc                            s0     s1     s2     ss     e0     e1     e2     ers    busy
        tv[0]  = mk(1, 0, 0, 4'b0000, 20'd0,                      24'd0,                        0, 4'b0000, 20'd0,                      24'd0,                        5'd5,  5'd1,  5'd31, 5'd31, 6'd5,  6'd1,  6'd31, 6'd31, 0);
        tv[1]  = mk(1, 0, 1, 4'b0101, {5'd0,5'd3,5'd0,5'd3},      {6'd0,6'd41,6'd0,6'd40},      0, 4'b0000, 20'd0,                      24'd0,                        5'd3,  5'd3,  5'd3,  5'd31, 6'd3,  6'd3,  6'd3,  6'd31, 0);
        tv[2]  = mk(1, 0, 1, 4'b1010, {5'd10,5'd0,5'd0,5'd0},     {6'd11,6'd0,6'd50,6'd0},      0, 4'b0000, 20'd0,                      24'd0,                        5'd3,  5'd0,  5'd10, 5'd31, 6'd41, 6'd0,  6'd10, 6'd31, 0);
        tv[3]  = mk(0, 0, 1, 4'b0001, {15'd0,5'd11},              {18'd0,6'd22},                1, 4'b0001, {15'd0,5'd11},              {18'd0,6'd23},                5'd0,  5'd10, 5'd11, 5'd11, 6'd0,  6'd11, 6'd11, 6'd11, 0);
        tv[4]  = mk(1, 0, 1, 4'b0001, {15'd0,5'd7},               {18'd0,6'd33},                1, 4'b0001, {15'd0,5'd7},               {18'd0,6'd20},                5'd11, 5'd3,  5'd10, 5'd11, 6'd11, 6'd41, 6'd11, 6'd11, 0);
        tv[5]  = mk(1, 1, 0, 4'b0000, 20'd0,                      24'd0,                        0, 4'b0000, 20'd0,                      24'd0,                        5'd7,  5'd0,  5'd0,  5'd7,  6'd33, 6'd0,  6'd0,  6'd20, 0);
        tv[6]  = mk(1, 0, 0, 4'b0000, 20'd0,                      24'd0,                        0, 4'b0000, 20'd0,                      24'd0,                        5'd7,  5'd3,  5'd10, 5'd31, 6'd33, 6'd41, 6'd11, 6'd31, 1);
        tv[7]  = mk(1, 0, 1, 4'b0001, {15'd0,5'd9},               {18'd0,6'd60},                0, 4'b0000, 20'd0,                      24'd0,                        5'd7,  5'd3,  5'd10, 5'd31, 6'd20, 6'd3,  6'd11, 6'd31, 1);
        tv[8]  = mk(1, 0, 0, 4'b0000, 20'd0,                      24'd0,                        0, 4'b0000, 20'd0,                      24'd0,                        5'd9,  5'd10, 5'd11, 5'd31, 6'd9,  6'd10, 6'd11, 6'd31, 1);
        tv[9]  = mk(1, 0, 0, 4'b0000, 20'd0,                      24'd0,                        0, 4'b0000, 20'd0,                      24'd0,                        5'd5,  5'd1,  5'd31, 5'd31, 6'd5,  6'd1,  6'd31, 6'd31, 1);
        tv[10] = mk(1, 0, 0, 4'b0000, 20'd0,                      24'd0,                        0, 4'b0000, 20'd0,                      24'd0,                        5'd7,  5'd9,  5'd10, 5'd7,  6'd20, 6'd9,  6'd10, 6'd20, 0);
        tv[11] = mk(1, 0, 0, 4'b0000, 20'd0,                      24'd0,                        1, 4'b1001, {5'd6,10'd0,5'd6},          {6'd26,12'd0,6'd16},          5'd6,  5'd0,  5'd31, 5'd31, 6'd6,  6'd0,  6'd31, 6'd31, 0);
        tv[12] = mk(1, 0, 0, 4'b0000, 20'd0,                      24'd0,                        0, 4'b0000, 20'd0,                      24'd0,                        5'd6,  5'd3,  5'd31, 5'd6,  6'd6,  6'd3,  6'd31, 6'd26, 0);

        repeat (3) @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            en = tv[i].en; rewind = tv[i].rw; reserve = tv[i].rsv;
            allowReserve = tv[i].ar; selectReserve = tv[i].sr; writeReserve = tv[i].wr;
            commit = tv[i].cm; allowCommit = tv[i].ac; selectCommit = tv[i].sc; writeCommit = tv[i].wc;
            select = tv[i].sel; selectStable = tv[i].ss;
            #1;
            check($sformatf("vec%0d_read", i), 32'(read), 32'(tv[i].exp_read));
            check($sformatf("vec%0d_readStable", i), 32'(readStable), 32'(tv[i].exp_rs));
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(tv[i].exp_busy));
        end

        // Commit mid-restore plus a second rewind that restarts the walk.
        @(negedge clk);
        idle_inputs();
        rewind = 1'b1;
        @(negedge clk);
        idle_inputs();
        for (int n = 1; n <= 7; n++) begin
            check($sformatf("rerewind_busy_T%0d", n), 32'(busy), 32'd1);
            if (n == 3) begin
                rewind = 1'b1;
                commit1(2, 5'd2, 6'd44);
            end
            @(negedge clk);
            idle_inputs();
        end
        check("rerewind_busy_T8", 32'(busy), 32'd0);
        select = {5'd6, 5'd7, 5'd2};
        #1;
        check("rerewind_read", 32'(read), 32'({6'd26, 6'd20, 6'd44}));

        // Reset asserted in the middle of a walk.
        @(negedge clk);
        idle_inputs();
        rewind = 1'b1;
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_mid_busy", 32'(busy), 32'd0);
        for (int i = 0; i < 32; i++) begin
            select = {10'd0, 5'(i)};
            selectStable = 5'(i);
            #1;
            check($sformatf("reset_newest%0d", i), 32'(read[PW-1:0]), 32'(i));
            check($sformatf("reset_stable%0d", i), 32'(readStable), 32'(i));
        end
        @(negedge clk);
        reset = 1'b1;

        // Stable read of a same-cycle commit.
        @(negedge clk);
        idle_inputs();
        selectStable = 5'd4;
        commit1(1, 5'd4, 6'd12);
        #1;
        check("stable_same_cycle", 32'(readStable), BYP ? 32'd12 : 32'd4);
        @(negedge clk);
        idle_inputs();
        selectStable = 5'd4;
        #1;
        check("stable_next_cycle", 32'(readStable), 32'd12);

        // en=0 pauses the walk and blocks commits and reserves.
        @(negedge clk);
        idle_inputs();
        rewind = 1'b1;
        @(negedge clk);
        for (int n = 1; n <= 7; n++) begin
            idle_inputs();
            if (n <= 3) begin
                en = 1'b0;
                reserve = 1'b1; allowReserve = 4'b0001; selectReserve = {15'd0, 5'd5}; writeReserve = {18'd0, 6'd55};
                commit1(0, 5'd5, 6'd55);
            end
            check($sformatf("pause_busy_T%0d", n), 32'(busy), 32'd1);
            @(negedge clk);
        end
        idle_inputs();
        check("pause_busy_T8", 32'(busy), 32'd0);
        select = {10'd0, 5'd5};
        selectStable = 5'd5;
        #1;
        check("pause_newest5", 32'(read[PW-1:0]), 32'd5);
        check("pause_stable5", 32'(readStable), 32'd5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
